// File: rtl/psi_section_parser.sv
// psi_section_parser
//   Watches a byte-wide MPEG-TS stream, follows PID 0 (PAT) and the PMT PID
//   announced by the last good PAT, and parses single-packet PSI sections.
//   A section is accepted only when its CRC-32/MPEG-2 residue is zero. The
//   PMT PID (from a PAT) and PCR PID (from a PMT) are then published with
//   one-cycle valid strobes.
// Ports
//   CLK, RST           clock, asynchronous active-low reset
//   DATA_IN/ENA_IN     TS byte and its qualifier
//   PSYNC              first byte of a packet (qualified by ENA_IN)
//   PMT_PID_OUT        PMT PID from the last good PAT
//   PCR_PID_OUT        PCR PID from the last good PMT
//   PAT_VALID/PMT_VALID good section committed (1-cycle pulse)
//   CRC_ERR            PAT/PMT section failed CRC (1-cycle pulse)
//   CC_ERR             continuity counter discontinuity (1-cycle pulse)
//   state_mon          parser state: IDLE=0 HEADER=1 POINTER=2 SECTION=3 SKIP=4
module psi_section_parser (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        ENA_IN,
  input  logic        PSYNC,
  output logic [12:0] PMT_PID_OUT,
  output logic [12:0] PCR_PID_OUT,
  output logic        PAT_VALID,
  output logic        PMT_VALID,
  output logic        CRC_ERR,
  output logic        CC_ERR,
  output logic [2:0]  state_mon
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_POINTER = 3'd2,
    S_SECTION = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      hidx_q;
  logic [12:0]     pid_q;
  logic            pusi_q;
  logic            tbl_pmt_q;
  logic            ptr_seen_q;
  logic [7:0]      ptr_rem_q;
  logic [7:0]      k_q;
  logic [11:0]     sec_len_q;
  logic [31:0]     crc_q;
  logic [12:0]     cand_q;
  logic            pmt_known_q;
  logic [1:0]      cc_valid_q;   // [0] PAT, [1] PMT
  logic [1:0][3:0] last_cc_q;

  logic        is_pat, is_pmt, tsel, hdr_go, sec_abort, sec_last;
  logic [11:0] len_now;
  logic [31:0] crc_nxt;

  // CRC-32/MPEG-2, one byte MSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ 32'h04C11DB7) : {r[30:0], 1'b0};
    return r;
  endfunction

  assign is_pat  = (pid_q == 13'h0000);
  assign is_pmt  = pmt_known_q && !is_pat && (pid_q == PMT_PID_OUT) && (pid_q != 13'h1FFF);
  assign tsel    = !is_pat;
  // evaluated on header byte 3: AFC lives in DATA_IN[5:4] of that byte
  assign hdr_go  = (is_pat || is_pmt) && pusi_q && (DATA_IN[5:4] == 2'b01);
  assign len_now = {sec_len_q[11:8], DATA_IN};
  assign sec_abort = ((k_q == 8'd0) && (DATA_IN != (tbl_pmt_q ? 8'h02 : 8'h00))) ||
                     ((k_q == 8'd2) && ((len_now < 12'd13) || (len_now > 12'd166)));
  // sec_len_q is only complete once k has passed 2
  assign sec_last = (k_q > 8'd2) && ({4'd0, k_q} == (sec_len_q + 12'd2));
  assign crc_nxt  = crc_byte((k_q == 8'd0) ? 32'hFFFFFFFF : crc_q, DATA_IN);

  assign state_mon = state_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ENA_IN) begin
      if (PSYNC) state_d = (DATA_IN == 8'h47) ? S_HEADER : S_IDLE;
      else begin
        case (state_q)
          S_HEADER:  if (hidx_q == 2'd3) state_d = hdr_go ? S_POINTER : S_SKIP;
          S_POINTER: begin
            if (!ptr_seen_q) begin
              if (DATA_IN >= 8'd170)     state_d = S_SKIP;
              else if (DATA_IN == 8'd0)  state_d = S_SECTION;
            end else if (ptr_rem_q == 8'd1) state_d = S_SECTION;
          end
          S_SECTION: if (sec_abort || sec_last) state_d = S_SKIP;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hidx_q      <= 2'd0;
      pid_q       <= 13'h0;
      pusi_q      <= 1'b0;
      tbl_pmt_q   <= 1'b0;
      ptr_seen_q  <= 1'b0;
      ptr_rem_q   <= 8'd0;
      k_q         <= 8'd0;
      sec_len_q   <= 12'd0;
      crc_q       <= 32'hFFFFFFFF;
      cand_q      <= 13'h0;
      pmt_known_q <= 1'b0;
      cc_valid_q  <= 2'b00;
      last_cc_q   <= '0;
      PMT_PID_OUT <= 13'h0;
      PCR_PID_OUT <= 13'h0;
      PAT_VALID   <= 1'b0;
      PMT_VALID   <= 1'b0;
      CRC_ERR     <= 1'b0;
      CC_ERR      <= 1'b0;
    end else begin
      PAT_VALID <= 1'b0;
      PMT_VALID <= 1'b0;
      CRC_ERR   <= 1'b0;
      CC_ERR    <= 1'b0;
      if (ENA_IN) begin
        if (PSYNC) hidx_q <= 2'd1;
        else begin
          case (state_q)
            S_HEADER: begin
              hidx_q <= 2'(hidx_q + 2'd1);
              case (hidx_q)
                2'd1: begin
                  pusi_q      <= DATA_IN[6];
                  pid_q[12:8] <= DATA_IN[4:0];
                end
                2'd2: pid_q[7:0] <= DATA_IN;
                2'd3: begin
                  tbl_pmt_q  <= tsel;
                  ptr_seen_q <= 1'b0;
                  k_q        <= 8'd0;
                  // continuity is tracked even for packets skipped below
                  if (is_pat || is_pmt) begin
                    if (cc_valid_q[tsel] && (DATA_IN[3:0] != last_cc_q[tsel] + 4'd1))
                      CC_ERR <= 1'b1;
                    last_cc_q[tsel]  <= DATA_IN[3:0];
                    cc_valid_q[tsel] <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
            S_POINTER: begin
              if (!ptr_seen_q) begin
                ptr_seen_q <= 1'b1;
                ptr_rem_q  <= DATA_IN;
              end else ptr_rem_q <= ptr_rem_q - 8'd1;
            end
            S_SECTION: begin
              k_q   <= k_q + 8'd1;
              crc_q <= crc_nxt;
              if (k_q == 8'd1) sec_len_q[11:8] <= DATA_IN[3:0];
              if (k_q == 8'd2) sec_len_q[7:0]  <= DATA_IN;
              if (k_q == (tbl_pmt_q ? 8'd8 : 8'd10)) cand_q[12:8] <= DATA_IN[4:0];
              if (k_q == (tbl_pmt_q ? 8'd9 : 8'd11)) cand_q[7:0]  <= DATA_IN;
              // residue over data plus CRC bytes is zero for a good section
              if (sec_last) begin
                if (crc_nxt == 32'h0) begin
                  if (!tbl_pmt_q) begin
                    PAT_VALID   <= 1'b1;
                    PMT_PID_OUT <= cand_q;
                    pmt_known_q <= 1'b1;
                    // a moved PMT restarts its continuity tracking
                    if (cand_q != PMT_PID_OUT) cc_valid_q[1] <= 1'b0;
                  end else begin
                    PMT_VALID   <= 1'b1;
                    PCR_PID_OUT <= cand_q;
                  end
                end else CRC_ERR <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_psi_section_parser.sv
module tb_psi_section_parser;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  DATA_IN = 8'h00;
  logic        ENA_IN = 1'b0;
  logic        PSYNC = 1'b0;
  logic [12:0] PMT_PID_OUT, PCR_PID_OUT;
  logic        PAT_VALID, PMT_VALID, CRC_ERR, CC_ERR;
  logic [2:0]  state_mon;

  psi_section_parser dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .PSYNC(PSYNC),
    .PMT_PID_OUT(PMT_PID_OUT), .PCR_PID_OUT(PCR_PID_OUT),
    .PAT_VALID(PAT_VALID), .PMT_VALID(PMT_VALID), .CRC_ERR(CRC_ERR),
    .CC_ERR(CC_ERR), .state_mon(state_mon)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] pkt [188];
  int   mon_e = -1;
  int   spur;
  logic obs_cc, obs_pat, obs_pmt, obs_crc;

  // reference model state
  bit          m_known;
  logic [12:0] m_pmt, m_pcr;
  bit          m_ccv [2];
  int          m_lcc [2];
  logic        e_cc, e_pat, e_pmt, e_crc;

  function automatic logic [31:0] crc_range(input int a, input int b);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int i = a; i <= b; i++)
      for (int j = 7; j >= 0; j--) begin
        fb = c[31] ^ pkt[i][j];
        c = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
      end
    return c;
  endfunction

  task automatic model_reset;
    m_known = 0; m_pmt = 13'h0; m_pcr = 13'h0;
    m_ccv[0] = 0; m_ccv[1] = 0; m_lcc[0] = 0; m_lcc[1] = 0;
  endtask

  // Build a single-packet PAT or PMT section with optional CRC corruption.
  task automatic build(input logic [12:0] pid, input int cc, input int ptr, input bit pmt,
                       input logic [12:0] val, input int extra, input logic [7:0] cx);
    logic [7:0]  sec[$];
    logic [11:0] len;
    logic [31:0] c;
    int s, e;
    len = 12'(13 + extra);
    for (int i = 0; i < 188; i++) pkt[i] = 8'hFF;
    pkt[0] = 8'h47; pkt[1] = {3'b010, pid[12:8]}; pkt[2] = pid[7:0];
    pkt[3] = {4'h1, 4'(cc)}; pkt[4] = 8'(ptr);
    sec.push_back(pmt ? 8'h02 : 8'h00); sec.push_back({4'hB, len[11:8]}); sec.push_back(len[7:0]);
    sec.push_back(8'h00); sec.push_back(8'h01); sec.push_back(8'hC1);
    sec.push_back(8'h00); sec.push_back(8'h00);
    if (pmt) begin
      sec.push_back({3'b111, val[12:8]}); sec.push_back(val[7:0]);
      sec.push_back(8'hF0); sec.push_back(8'h00);
    end else begin
      sec.push_back(8'h00); sec.push_back(8'h01);
      sec.push_back({3'b111, val[12:8]}); sec.push_back(val[7:0]);
    end
    for (int i = 0; i < extra; i++) sec.push_back(8'($urandom));
    s = 5 + ptr;
    foreach (sec[i]) pkt[s + i] = sec[i];
    e = s + sec.size() - 1;
    c = crc_range(s, e);
    pkt[e + 1] = c[31:24]; pkt[e + 2] = c[23:16]; pkt[e + 3] = c[15:8]; pkt[e + 4] = c[7:0] ^ cx;
  endtask

  // Predict pulses for the first n bytes of pkt and update model state.
  task automatic model(input int n);
    logic [12:0] pid, cand;
    logic [31:0] got;
    int t, ptr, s, len, e;
    e_cc = 0; e_pat = 0; e_pmt = 0; e_crc = 0; mon_e = -1;
    if (n < 4) return;
    pid = {pkt[1][4:0], pkt[2]};
    if (pid == 13'h0) t = 0;
    else if (m_known && pid == m_pmt && pid != 13'h1FFF) t = 1;
    else return;
    if (m_ccv[t] && int'(pkt[3][3:0]) != (m_lcc[t] + 1) % 16) e_cc = 1;
    m_lcc[t] = int'(pkt[3][3:0]); m_ccv[t] = 1;
    if (!pkt[1][6] || pkt[3][5:4] != 2'b01 || n < 5) return;
    ptr = int'(pkt[4]);
    if (ptr >= 170) return;
    s = 5 + ptr;
    if (s + 2 >= n) return;
    if (pkt[s] != ((t == 1) ? 8'h02 : 8'h00)) return;
    len = int'({pkt[s + 1][3:0], pkt[s + 2]});
    if (len < 13 || len > 166) return;
    e = s + 2 + len;
    if (e >= n) return;
    mon_e = e;
    got  = {pkt[e - 3], pkt[e - 2], pkt[e - 1], pkt[e]};
    cand = (t == 1) ? {pkt[s + 8][4:0], pkt[s + 9]} : {pkt[s + 10][4:0], pkt[s + 11]};
    if (crc_range(s, e - 4) !== got) begin e_crc = 1; return; end
    if (t == 0) begin
      e_pat = 1;
      if (cand != m_pmt) m_ccv[1] = 0;
      m_pmt = cand; m_known = 1;
    end else begin
      e_pmt = 1; m_pcr = cand;
    end
  endtask

  // One clock: drive at negedge, observe 1 time unit after posedge.
  task automatic step(input logic ena, input logic ps, input logic [7:0] d, input int idx);
    ENA_IN = ena; PSYNC = ps; DATA_IN = d;
    @(posedge CLK); #1;
    if (idx == 3) obs_cc = CC_ERR;
    else if (CC_ERR) spur++;
    if (idx >= 0 && idx == mon_e) begin
      obs_pat = PAT_VALID; obs_pmt = PMT_VALID; obs_crc = CRC_ERR;
    end else spur += int'(PAT_VALID) + int'(PMT_VALID) + int'(CRC_ERR);
    @(negedge CLK);
  endtask

  task automatic run(input int n, input bit gaps, input bit flush);
    model(n);
    obs_cc = 0; obs_pat = 0; obs_pmt = 0; obs_crc = 0; spur = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; gaps && g < 3 && $urandom_range(0, 2) == 0; g++) step(1'b0, 1'b0, 8'h00, -1);
      step(1'b1, i == 0, pkt[i], i);
    end
    if (flush) repeat (3) step(1'b0, 1'b0, 8'h00, -1);
  endtask

  task automatic apply_reset;
    ENA_IN = 0; PSYNC = 0; RST = 0;
    repeat (2) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    model_reset;
  endtask

  task automatic test_reset;
    ENA_IN = 0; PSYNC = 0; RST = 0;
    repeat (2) @(negedge CLK);
    tests_run++; if (PMT_PID_OUT !== 13'h0) begin tests_failed++; $display("FAIL reset.pmt_pid got %0h want 0", PMT_PID_OUT); end
    tests_run++; if (PCR_PID_OUT !== 13'h0) begin tests_failed++; $display("FAIL reset.pcr_pid got %0h want 0", PCR_PID_OUT); end
    tests_run++; if ({PAT_VALID, PMT_VALID, CRC_ERR, CC_ERR} !== 4'b0) begin tests_failed++; $display("FAIL reset.pulses got %b want 0000", {PAT_VALID, PMT_VALID, CRC_ERR, CC_ERR}); end
    tests_run++; if (state_mon !== 3'd0) begin tests_failed++; $display("FAIL reset.state got %0d want 0", state_mon); end
    RST = 1;
    @(negedge CLK);
    model_reset;
  endtask

  task automatic test_pmt_before_pat;
    build(13'h100, 0, 0, 1'b1, 13'h101, 0, 8'h00);
    run(188, 1'b0, 1'b1);
    tests_run++; if (obs_pmt !== e_pmt) begin tests_failed++; $display("FAIL early_pmt.pmt_valid got %0b want %0b", obs_pmt, e_pmt); end
    tests_run++; if (spur !== 0) begin tests_failed++; $display("FAIL early_pmt.stray_pulses got %0d want 0", spur); end
    tests_run++; if (PCR_PID_OUT !== m_pcr) begin tests_failed++; $display("FAIL early_pmt.pcr_pid got %0h want %0h", PCR_PID_OUT, m_pcr); end
  endtask

  task automatic test_pat_basic;
    build(13'h0, 0, 0, 1'b0, 13'h100, 0, 8'h00);
    run(188, 1'b0, 1'b1);
    tests_run++; if (obs_pat !== e_pat) begin tests_failed++; $display("FAIL pat.pat_valid got %0b want %0b", obs_pat, e_pat); end
    tests_run++; if (PMT_PID_OUT !== m_pmt) begin tests_failed++; $display("FAIL pat.pmt_pid got %0h want %0h", PMT_PID_OUT, m_pmt); end
    tests_run++; if (spur !== 0) begin tests_failed++; $display("FAIL pat.stray_pulses got %0d want 0", spur); end
  endtask

  task automatic test_pmt_basic;
    build(13'h100, 1, 0, 1'b1, 13'h101, 0, 8'h00);
    run(188, 1'b0, 1'b1);
    tests_run++; if (obs_pmt !== e_pmt) begin tests_failed++; $display("FAIL pmt.pmt_valid got %0b want %0b", obs_pmt, e_pmt); end
    tests_run++; if (PCR_PID_OUT !== m_pcr) begin tests_failed++; $display("FAIL pmt.pcr_pid got %0h want %0h", PCR_PID_OUT, m_pcr); end
    tests_run++; if (spur !== 0) begin tests_failed++; $display("FAIL pmt.stray_pulses got %0d want 0", spur); end
  endtask

  task automatic test_crc_err;
    build(13'h0, (m_lcc[0] + 1) % 16, 0, 1'b0, 13'h155, 0, 8'h01);
    run(188, 1'b0, 1'b1);
    tests_run++; if (obs_crc !== e_crc) begin tests_failed++; $display("FAIL crc.crc_err got %0b want %0b", obs_crc, e_crc); end
    tests_run++; if (obs_pat !== e_pat) begin tests_failed++; $display("FAIL crc.pat_valid got %0b want %0b", obs_pat, e_pat); end
    tests_run++; if (PMT_PID_OUT !== m_pmt) begin tests_failed++; $display("FAIL crc.pmt_pid got %0h want %0h", PMT_PID_OUT, m_pmt); end
  endtask

  task automatic test_cc_seq;
    int ccs[4] = '{14, 15, 0, 2};
    int n_obs, n_exp;
    apply_reset;
    n_obs = 0; n_exp = 0;
    foreach (ccs[i]) begin
      build(13'h0, ccs[i], 0, 1'b0, 13'h100, 0, 8'h00);
      run(188, 1'b0, 1'b1);
      n_obs += int'(obs_cc); n_exp += int'(e_cc);
      tests_run++; if (obs_cc !== e_cc) begin tests_failed++; $display("FAIL cc_seq.cc_err[cc=%0d] got %0b want %0b", ccs[i], obs_cc, e_cc); end
    end
    tests_run++; if (n_obs !== n_exp) begin tests_failed++; $display("FAIL cc_seq.count got %0d want %0d", n_obs, n_exp); end
  endtask

  task automatic test_pointer_gaps;
    build(13'h0, (m_lcc[0] + 1) % 16, 3, 1'b0, 13'h100, 0, 8'h00);
    run(188, 1'b1, 1'b1);
    tests_run++; if (obs_pat !== e_pat) begin tests_failed++; $display("FAIL ptr_gaps.pat_valid got %0b want %0b", obs_pat, e_pat); end
    tests_run++; if (PMT_PID_OUT !== m_pmt) begin tests_failed++; $display("FAIL ptr_gaps.pmt_pid got %0h want %0h", PMT_PID_OUT, m_pmt); end
  endtask

  task automatic test_abort;
    build(13'h0, (m_lcc[0] + 1) % 16, 0, 1'b0, 13'h0AB, 0, 8'h00);
    run(11, 1'b0, 1'b0);   // stops where section byte k=6 would be
    tests_run++; if (spur !== 0) begin tests_failed++; $display("FAIL abort.partial_pulses got %0d want 0", spur); end
    build(13'h0, (m_lcc[0] + 1) % 16, 0, 1'b0, 13'h0AB, 0, 8'h00);
    run(188, 1'b0, 1'b1);
    tests_run++; if (obs_pat !== e_pat) begin tests_failed++; $display("FAIL abort.pat_valid got %0b want %0b", obs_pat, e_pat); end
    tests_run++; if (spur !== 0) begin tests_failed++; $display("FAIL abort.stray_pulses got %0d want 0", spur); end
    tests_run++; if (PMT_PID_OUT !== m_pmt) begin tests_failed++; $display("FAIL abort.pmt_pid got %0h want %0h", PMT_PID_OUT, m_pmt); end
  endtask

  task automatic test_back_to_back;
    // section ends on byte 187, next PSYNC arrives the very next cycle
    build(13'h0, (m_lcc[0] + 1) % 16, 14, 1'b0, 13'h0AB, 153, 8'h00);
    run(188, 1'b0, 1'b0);
    tests_run++; if (obs_pat !== e_pat) begin tests_failed++; $display("FAIL b2b.pat_valid got %0b want %0b", obs_pat, e_pat); end
    build(m_pmt, (m_lcc[1] + 1) % 16, 0, 1'b1, 13'h1AB, 5, 8'h00);
    run(188, 1'b0, 1'b1);
    tests_run++; if (obs_pmt !== e_pmt) begin tests_failed++; $display("FAIL b2b.pmt_valid got %0b want %0b", obs_pmt, e_pmt); end
    tests_run++; if (PCR_PID_OUT !== m_pcr) begin tests_failed++; $display("FAIL b2b.pcr_pid got %0h want %0h", PCR_PID_OUT, m_pcr); end
  endtask

  task automatic test_reset_mid;
    build(13'h0, (m_lcc[0] + 1) % 16, 30, 1'b0, 13'h0CD, 0, 8'h00);
    run(40, 1'b0, 1'b0);
    tests_run++; if (state_mon !== 3'd3) begin tests_failed++; $display("FAIL reset_mid.state_before got %0d want 3", state_mon); end
    ENA_IN = 0; PSYNC = 0; RST = 0;
    #1;
    tests_run++; if (state_mon !== 3'd0) begin tests_failed++; $display("FAIL reset_mid.state got %0d want 0", state_mon); end
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    model_reset;
    build(13'h0, 9, 0, 1'b0, 13'h0CD, 0, 8'h00);
    run(188, 1'b0, 1'b1);
    tests_run++; if (obs_pat !== e_pat) begin tests_failed++; $display("FAIL reset_mid.pat_valid got %0b want %0b", obs_pat, e_pat); end
    tests_run++; if (obs_cc !== e_cc) begin tests_failed++; $display("FAIL reset_mid.cc_err got %0b want %0b", obs_cc, e_cc); end
    tests_run++; if (PMT_PID_OUT !== m_pmt) begin tests_failed++; $display("FAIL reset_mid.pmt_pid got %0h want %0h", PMT_PID_OUT, m_pmt); end
  endtask

  task automatic test_random;
    logic [12:0] pid, val;
    int r, cc, ptr, extra, mut, s;
    bit pmt;
    logic [7:0] cx;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      pid = 13'h0;
      else if (r < 7) pid = m_known ? m_pmt : 13'h100;
      else if (r == 7) pid = 13'h1FFF;
      else            pid = 13'($urandom_range(1, 13'h1FFE));
      pmt   = (pid != 13'h0) ? 1'b1 : ($urandom_range(0, 5) == 0);
      cc    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : (m_lcc[(pid == 13'h0) ? 0 : 1] + 1) % 16;
      ptr   = $urandom_range(0, 8);
      extra = $urandom_range(0, 40);
      cx    = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      val   = ($urandom_range(0, 2) == 0) ? 13'h100 : 13'($urandom_range(1, 13'h1FFE));
      build(pid, cc, ptr, pmt, val, extra, cx);
      s   = 5 + ptr;
      mut = $urandom_range(0, 11);
      case (mut)
        0: pkt[1][6] = 1'b0;
        1: pkt[3][5:4] = 2'b11;
        2: pkt[4] = 8'($urandom_range(170, 255));
        3: begin pkt[s + 1] = 8'hB0; pkt[s + 2] = 8'($urandom_range(0, 12)); end
        4: begin pkt[s + 1] = 8'hB0; pkt[s + 2] = 8'($urandom_range(167, 255)); end
        default: ;
      endcase
      run(188, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      tests_run++; if (obs_cc !== e_cc) begin tests_failed++; $display("FAIL rand[%0d].cc_err got %0b want %0b", it, obs_cc, e_cc); end
      tests_run++; if (obs_pat !== e_pat) begin tests_failed++; $display("FAIL rand[%0d].pat_valid got %0b want %0b", it, obs_pat, e_pat); end
      tests_run++; if (obs_pmt !== e_pmt) begin tests_failed++; $display("FAIL rand[%0d].pmt_valid got %0b want %0b", it, obs_pmt, e_pmt); end
      tests_run++; if (obs_crc !== e_crc) begin tests_failed++; $display("FAIL rand[%0d].crc_err got %0b want %0b", it, obs_crc, e_crc); end
      tests_run++; if (spur !== 0) begin tests_failed++; $display("FAIL rand[%0d].stray_pulses got %0d want 0", it, spur); end
      tests_run++; if (PMT_PID_OUT !== m_pmt) begin tests_failed++; $display("FAIL rand[%0d].pmt_pid got %0h want %0h", it, PMT_PID_OUT, m_pmt); end
      tests_run++; if (PCR_PID_OUT !== m_pcr) begin tests_failed++; $display("FAIL rand[%0d].pcr_pid got %0h want %0h", it, PCR_PID_OUT, m_pcr); end
    end
  endtask

  initial begin
    model_reset;
    @(negedge CLK);
    test_reset;
    test_pmt_before_pat;
    test_pat_basic;
    test_pmt_basic;
    test_crc_err;
    test_cc_seq;
    test_pointer_gaps;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
